pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  pipeline clock, all state updates on rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have: memRead_EX  in  1  instruction in EX is a load.
REQ-004 SHALL have: targetReg_EX  in  5  destination register of EX instruction.
REQ-005 SHALL have: rn_ID, rm_ID  in  5 each  source registers of ID instruction; rm_used_ID  in  1  rm_ID is a real operand.
REQ-006 SHALL have: branchTaken_EX  in  1  branch resolved taken in EX.
REQ-007 SHALL have: mem_busy  in  1  data memory not ready this cycle.
REQ-008 SHALL have: pc_write, IF_ID_write  out  1  enable PC and IF/ID updates.
REQ-009 SHALL have: IF_ID_flush, ID_EX_bubble  out  1  zero IF/ID instruction, zero ID/EX control fields.
REQ-010 SHALL have: EX_MEM_hold  out  1; state  out  2; mem_timeout  out  1  sticky error.

Function
REQ-011 SHALL implement FSM: RUN=00, LOADUSE=01, FLUSH=10, MEMWAIT=11; state output equals current state.
REQ-012 SHALL detect load-use = memRead_EX & targetReg_EX!=31 & (targetReg_EX==rn_ID | (rm_used_ID & targetReg_EX==rm_ID)); X31 never hazards.
REQ-013 SHALL evaluate events combinationally each cycle with priority mem_busy > branchTaken_EX > load-use > none.
REQ-014 SHALL, on mem_busy: pc_write=0, IF_ID_write=0, ID_EX_bubble=0, EX_MEM_hold=1, next state MEMWAIT.
REQ-015 SHALL, on branchTaken_EX (no mem_busy): IF_ID_flush=1, ID_EX_bubble=1, pc_write=1, IF_ID_write=1, next state FLUSH.
REQ-016 SHALL, on load-use (no higher event): pc_write=0, IF_ID_write=0, ID_EX_bubble=1, next state LOADUSE.
REQ-017 SHALL, with no event: pc_write=1, IF_ID_write=1, all others 0, next state RUN.
REQ-018 SHALL suppress load-use in LOADUSE state: a single load produces exactly one stall cycle.
REQ-019 SHALL leave MEMWAIT to RUN the cycle after mem_busy deasserts; a branch or load-use pending at exit is evaluated normally that cycle.
REQ-020 SHALL count consecutive mem_busy cycles in an 8-bit counter, cleared when mem_busy=0; on reaching 255 set mem_timeout, held until reset; counter saturates.
REQ-021 SHALL treat branchTaken_EX while stalled in MEMWAIT as ignored until mem_busy drops (EX is frozen, signal persists).
REQ-022 SHALL be fully combinational in output path from inputs (Mealy), zero-cycle latency.

Reset
REQ-023 SHALL on reset: state=RUN, timeout counter=0, mem_timeout=0, statistic counters=0.
REQ-024 SHALL, during reset cycle, drive pc_write=0, IF_ID_write=0, IF_ID_flush=1, ID_EX_bubble=1, EX_MEM_hold=0, overriding all events.
REQ-025 SHALL abandon any stall mid-operation on reset; first post-reset cycle behaves per RUN.

Configuration
REQ-026 SHALL, with HAZ_STATS_EN defined, add outputs stall_cnt[15:0] (LOADUSE+MEMWAIT entry cycles, i.e. cycles with pc_write=0 outside reset) and flush_cnt[15:0] (cycles with IF_ID_flush=1 outside reset), both saturating at 16'hFFFF, reset to 0.
REQ-027 SHALL, without HAZ_STATS_EN, omit these ports and counters entirely; all other behaviour identical.

Verification
REQ-028 Load X5 in EX, ID uses rn=5 -> one cycle pc_write=0, ID_EX_bubble=1, state=01; next cycle pc_write=1.
REQ-029 Load to X31, ID rn=31 -> no stall, pc_write=1; rm_ID match with rm_used_ID=0 -> no stall.
REQ-030 branchTaken_EX and load-use same cycle -> IF_ID_flush=1, ID_EX_bubble=1, pc_write=1, state next=10.
REQ-031 mem_busy 3 cycles with branchTaken_EX high -> 3 cycles EX_MEM_hold=1, pc_write=0; then flush cycle.
REQ-032 mem_busy 255 cycles -> mem_timeout=1 and stays 1 after mem_busy drops until reset.
REQ-033 reset asserted in LOADUSE -> next state RUN, mem_timeout=0; with HAZ_STATS_EN stall_cnt=0 after 2 stalls then reset.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl -- pipeline hazard controller for a five-stage in-order core.
//
// Decides each cycle whether the front end advances, stalls, or flushes,
// based on the events visible this cycle: a data-memory stall, a taken branch
// resolved in EX, or a load-use dependency between EX and ID. The outputs are
// Mealy outputs: a combinational function of this cycle's inputs plus the
// current state, so they act with zero cycles of latency.
//
// Optional feature: define HAZ_STATS_EN to add the stall_cnt / flush_cnt
// statistic outputs. The default build leaves both the ports and the counters out.
//
// Ports:
//   clk            in   pipeline clock, rising edge
//   reset          in   synchronous, active-high reset
//   memRead_EX     in   EX instruction is a load
//   targetReg_EX   in   [4:0] destination register of the EX instruction
//   rn_ID, rm_ID   in   [4:0] source registers of the ID instruction
//   rm_used_ID     in   rm_ID is a real operand
//   branchTaken_EX in   branch resolved taken in EX
//   mem_busy       in   data memory not ready this cycle
//   pc_write       out  enable PC update
//   IF_ID_write    out  enable IF/ID update
//   IF_ID_flush    out  zero the IF/ID instruction
//   ID_EX_bubble   out  zero the ID/EX control fields
//   EX_MEM_hold    out  hold EX/MEM while memory is busy
//   state          out  [1:0] current state: RUN=00 LOADUSE=01 FLUSH=10 MEMWAIT=11
//   mem_timeout    out  sticky: 255 consecutive mem_busy cycles seen
//   stall_cnt      out  [15:0] (HAZ_STATS_EN) cycles with pc_write=0, excluding reset
//   flush_cnt      out  [15:0] (HAZ_STATS_EN) cycles with IF_ID_flush=1, excluding reset
module pipe_hazard_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       memRead_EX,
    input  logic [4:0] targetReg_EX,
    input  logic [4:0] rn_ID,
    input  logic [4:0] rm_ID,
    input  logic       rm_used_ID,
    input  logic       branchTaken_EX,
    input  logic       mem_busy,
    output logic       pc_write,
    output logic       IF_ID_write,
    output logic       IF_ID_flush,
    output logic       ID_EX_bubble,
    output logic       EX_MEM_hold,
    output logic [1:0] state,
    output logic       mem_timeout
`ifdef HAZ_STATS_EN
    ,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        LOADUSE = 2'b01,
        FLUSH   = 2'b10,
        MEMWAIT = 2'b11
    } state_t;

    state_t     cur_state;
    state_t     next_state;
    logic       load_use;
    logic [7:0] busy_cnt;

    // X31 is the zero register, so it can never carry a dependency. While in
    // LOADUSE the stalled consumer is still in ID but the load has moved on,
    // so the detector is masked to give exactly one stall cycle per load.
    always_comb begin
        load_use = memRead_EX && (targetReg_EX != 5'd31) &&
                   ((targetReg_EX == rn_ID) || (rm_used_ID && (targetReg_EX == rm_ID))) &&
                   (cur_state != LOADUSE);
    end

    // Event priority: mem_busy > taken branch > load-use > none. A branch that
    // arrives during a memory stall simply waits: EX is frozen, so the signal
    // is still present when mem_busy drops and is handled on that cycle.
    always_comb begin
        pc_write     = 1'b1;
        IF_ID_write  = 1'b1;
        IF_ID_flush  = 1'b0;
        ID_EX_bubble = 1'b0;
        EX_MEM_hold  = 1'b0;
        next_state   = RUN;
        if (reset) begin
            pc_write     = 1'b0;
            IF_ID_write  = 1'b0;
            IF_ID_flush  = 1'b1;
            ID_EX_bubble = 1'b1;
        end else if (mem_busy) begin
            pc_write    = 1'b0;
            IF_ID_write = 1'b0;
            EX_MEM_hold = 1'b1;
            next_state  = MEMWAIT;
        end else if (branchTaken_EX) begin
            IF_ID_flush  = 1'b1;
            ID_EX_bubble = 1'b1;
            next_state   = FLUSH;
        end else if (load_use) begin
            pc_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_bubble = 1'b1;
            next_state   = LOADUSE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state   <= RUN;
            busy_cnt    <= 8'd0;
            mem_timeout <= 1'b0;
        end else begin
            cur_state <= next_state;
            if (mem_busy) begin
                if (busy_cnt != 8'hFF) busy_cnt <= busy_cnt + 8'd1;
                // Flag on the edge where the run length reaches 255.
                if (busy_cnt >= 8'hFE) mem_timeout <= 1'b1;
            end else begin
                busy_cnt <= 8'd0;
            end
        end
    end

    assign state = cur_state;

`ifdef HAZ_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else begin
            if (!pc_write && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
            if (IF_ID_flush && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset, memRead_EX, rm_used_ID, branchTaken_EX, mem_busy;
    logic [4:0] targetReg_EX, rn_ID, rm_ID;
    logic       pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, EX_MEM_hold, mem_timeout;
    logic [1:0] state;
`ifdef HAZ_STATS_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    // Reference model: the event of the previous cycle, the current run of
    // busy cycles, and the sticky timeout flag.
    int m_prev_ev = 0;   // 0 none, 1 load-use stall, 2 branch flush, 3 memory wait
    int m_busy_run = 0;
    bit m_timeout = 0;
    int m_stalls = 0;
    int m_flushes = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk(clk), .reset(reset), .memRead_EX(memRead_EX), .targetReg_EX(targetReg_EX),
        .rn_ID(rn_ID), .rm_ID(rm_ID), .rm_used_ID(rm_used_ID),
        .branchTaken_EX(branchTaken_EX), .mem_busy(mem_busy),
        .pc_write(pc_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
        .ID_EX_bubble(ID_EX_bubble), .EX_MEM_hold(EX_MEM_hold), .state(state),
        .mem_timeout(mem_timeout)
`ifdef HAZ_STATS_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    task automatic step(input string tag, input logic rst, input logic mr, input logic [4:0] tg,
                        input logic [4:0] rn, input logic [4:0] rm, input logic ru,
                        input logic br, input logic mb);
        int ev;
        bit dep;
        logic [7:0] exp_v, obs_v;
        reset = rst; memRead_EX = mr; targetReg_EX = tg; rn_ID = rn; rm_ID = rm;
        rm_used_ID = ru; branchTaken_EX = br; mem_busy = mb;
        #1;
        dep = mr && (tg != 5'd31) && (tg == rn || (ru && tg == rm)) && (m_prev_ev != 1);
        if (rst)      ev = -1;
        else if (mb)  ev = 3;
        else if (br)  ev = 2;
        else if (dep) ev = 1;
        else          ev = 0;
        // {state, pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, EX_MEM_hold, mem_timeout}
        case (ev)
            -1:      exp_v[5:1] = 5'b00110;
            1:       exp_v[5:1] = 5'b00010;
            2:       exp_v[5:1] = 5'b11110;
            3:       exp_v[5:1] = 5'b00001;
            default: exp_v[5:1] = 5'b11000;
        endcase
        exp_v[7:6] = 2'(m_prev_ev);
        exp_v[0]   = m_timeout;
        obs_v = {state, pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, EX_MEM_hold, mem_timeout};
        vectors++;
        assert (obs_v === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b (st,pc,ifw,fl,bub,hold,to)", tag, obs_v, exp_v);
        end
`ifdef HAZ_STATS_EN
        vectors++;
        assert ({stall_cnt, flush_cnt} === {16'(m_stalls), 16'(m_flushes)}) else begin
            miscompares++;
            $error("FAIL %s stats: observed %0d/%0d expected %0d/%0d", tag,
                   stall_cnt, flush_cnt, m_stalls, m_flushes);
        end
`endif
        @(posedge clk);
        if (rst) begin
            m_prev_ev = 0; m_busy_run = 0; m_timeout = 0; m_stalls = 0; m_flushes = 0;
        end else begin
            m_prev_ev = ev;
            if (ev == 1 || ev == 3) m_stalls = (m_stalls < 65535) ? m_stalls + 1 : 65535;
            if (ev == 2) m_flushes = (m_flushes < 65535) ? m_flushes + 1 : 65535;
            if (mb) begin
                m_busy_run = (m_busy_run < 255) ? m_busy_run + 1 : 255;
                if (m_busy_run == 255) m_timeout = 1;
            end else begin
                m_busy_run = 0;
            end
        end
        #1;
    endtask

    function automatic logic [4:0] pick_reg();
        int r = int'($urandom_range(0, 4));
        return (r == 4) ? 5'd31 : 5'(r);
    endfunction

    initial begin
        // reset and idle
        step("reset0", 1, 0, 0, 0, 0, 0, 0, 0);
        step("reset_busy", 1, 1, 5, 5, 0, 0, 1, 1);
        step("idle", 0, 0, 0, 0, 0, 0, 0, 0);
        // single load-use stall, held inputs must not stall twice
        step("lu_stall", 0, 1, 5, 5, 0, 0, 0, 0);
        step("lu_release", 0, 1, 5, 5, 0, 0, 0, 0);
        step("lu_after", 0, 0, 0, 0, 0, 0, 0, 0);
        // X31 and unused rm never hazard; used rm does
        step("x31", 0, 1, 31, 31, 31, 1, 0, 0);
        step("rm_unused", 0, 1, 7, 1, 7, 0, 0, 0);
        step("rm_used", 0, 1, 7, 1, 7, 1, 0, 0);
        step("idle2", 0, 0, 0, 0, 0, 0, 0, 0);
        // branch beats load-use
        step("br_lu", 0, 1, 3, 3, 0, 0, 1, 0);
        step("post_flush", 0, 0, 0, 0, 0, 0, 0, 0);
        // memory wait with pending branch, then flush on exit
        for (int i = 0; i < 3; i++) step("busy_br", 0, 0, 0, 0, 0, 0, 1, 1);
        step("exit_flush", 0, 0, 0, 0, 0, 0, 1, 0);
        step("idle3", 0, 0, 0, 0, 0, 0, 0, 0);
        // two stalls, then reset while in LOADUSE
        step("lu_a", 0, 1, 2, 2, 0, 0, 0, 0);
        step("run_a", 0, 0, 0, 0, 0, 0, 0, 0);
        step("lu_b", 0, 1, 4, 0, 4, 1, 0, 0);
        step("reset_in_lu", 1, 1, 4, 0, 4, 1, 0, 0);
        step("post_reset", 0, 0, 0, 0, 0, 0, 0, 0);
        // timeout boundary: 254 busy cycles do not trip it, the 255th does
        for (int i = 0; i < 254; i++) step("busy_254", 0, 0, 0, 0, 0, 0, 0, 1);
        step("busy_255", 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step("timeout_sticky", 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 300; i++) step("busy_sat", 0, 0, 0, 0, 0, 0, 0, 1);
        step("to_clear", 1, 0, 0, 0, 0, 0, 0, 0);
        step("to_cleared", 0, 0, 0, 0, 0, 0, 0, 0);
        // random traffic
        for (int i = 0; i < 3000; i++)
            step("random", ($urandom_range(0, 63) == 0), 1'($urandom), pick_reg(), pick_reg(),
                 pick_reg(), 1'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
